// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - multi-cycle shift-add multiply sequencer driving the shared ALU
// Optional feature macro: ALU_MUL_SIGNED_EN (two's complement operands when defined).
// Ports:
//   Clock, Reset          rising-edge clock, synchronous active-high reset
//   Start, MulA, MulB     multiply request and operands (sampled in IDLE)
//   Busy, Done, Product   status and 2*WIDTH-bit registered result
//   AluA, AluB, AluOp,    operands/opcode/adder controls to the shared ALU
//   AluBInvert, AluCin
//   AluResult,            ALU sum, carry out of the MSB and signed overflow
//   AluCarryOut, AluOverflow
module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [WIDTH-1:0]     MulA,
  input  logic [WIDTH-1:0]     MulB,
  output logic                 Busy,
  output logic                 Done,
  output logic [2*WIDTH-1:0]   Product,
  output logic [WIDTH-1:0]     AluA,
  output logic [WIDTH-1:0]     AluB,
  output logic [2:0]           AluOp,
  output logic                 AluBInvert,
  output logic                 AluCin,
  input  logic [WIDTH-1:0]     AluResult,
  input  logic                 AluCarryOut,
  input  logic                 AluOverflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_product;
  logic               w_last;
  logic               w_ext;
  logic [2*WIDTH-1:0] w_shifted;
  logic               w_unused;

  assign w_last = (r_cnt == CW'(WIDTH - 1));

`ifdef ALU_MUL_SIGNED_EN
  // True sign of the WIDTH+1-bit sum: result MSB corrected by overflow.
  assign w_ext    = AluResult[WIDTH-1] ^ AluOverflow;
  assign w_unused = AluCarryOut;
`else
  assign w_ext    = AluCarryOut;
  assign w_unused = AluOverflow;
`endif

  // New {Hi, Lo}: sum with its extension bit goes high, multiplier shifts out.
  assign w_shifted = {w_ext, AluResult, r_lo[WIDTH-1:1]};

  always_comb begin
    w_next_state = r_state;
    Busy         = 1'b0;
    Done         = 1'b0;
    AluA         = '0;
    AluB         = '0;
    AluOp        = 3'b000;
    AluBInvert   = 1'b0;
    AluCin       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start) w_next_state = S_ITER;
      end
      S_ITER: begin
        Busy  = 1'b1;
        AluA  = r_hi;
        AluB  = r_lo[0] ? r_mcand : '0;
        AluOp = 3'b100;
`ifdef ALU_MUL_SIGNED_EN
        // Multiplier sign bit carries negative weight: subtract on the last step.
        if (w_last && r_lo[0]) begin
          AluBInvert = 1'b1;
          AluCin     = 1'b1;
        end
`endif
        if (w_last) w_next_state = S_DONE;
      end
      S_DONE: begin
        Done         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_mcand <= MulA;
            r_hi    <= '0;
            r_lo    <= MulB;
            r_cnt   <= '0;
          end
        end
        S_ITER: begin
          {r_hi, r_lo} <= w_shifted;
          r_cnt        <= r_cnt + CW'(1);
          if (w_last) r_product <= w_shifted;
        end
        default: ;
      endcase
    end
  end

  assign Product = r_product;

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb/tb_alu_mul_seq.sv - randomized self-checking bench for alu_mul_seq with an ALU model
module tb_alu_mul_seq;

  localparam int W = 16;

  logic            Clock = 1'b0;
  logic            Reset;
  logic            Start;
  logic [W-1:0]    MulA, MulB;
  logic            Busy, Done;
  logic [2*W-1:0]  Product;
  logic [W-1:0]    AluA, AluB;
  logic [2:0]      AluOp;
  logic            AluBInvert, AluCin;
  logic [W-1:0]    AluResult;
  logic            AluCarryOut, AluOverflow;

  int checks = 0;
  int failures = 0;

  alu_mul_seq #(.WIDTH(W)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .MulA(MulA), .MulB(MulB),
    .Busy(Busy), .Done(Done), .Product(Product),
    .AluA(AluA), .AluB(AluB), .AluOp(AluOp), .AluBInvert(AluBInvert), .AluCin(AluCin),
    .AluResult(AluResult), .AluCarryOut(AluCarryOut), .AluOverflow(AluOverflow)
  );

  always #5 Clock = ~Clock;

  // Shared ALU: adder path for op 3'b100, AND otherwise.
  logic [W:0]   alu_sum;
  logic [W-1:0] alu_low;
  logic [W-1:0] alu_bm;
  always_comb begin
    alu_bm      = AluBInvert ? ~AluB : AluB;
    alu_sum     = {1'b0, AluA} + {1'b0, alu_bm} + {{W{1'b0}}, AluCin};
    alu_low     = {1'b0, AluA[W-2:0]} + {1'b0, alu_bm[W-2:0]} + {{(W-1){1'b0}}, AluCin};
    if (AluOp == 3'b100) begin
      AluResult   = alu_sum[W-1:0];
      AluCarryOut = alu_sum[W];
      AluOverflow = alu_low[W-1] ^ alu_sum[W];
    end else begin
      AluResult   = AluA & AluB;
      AluCarryOut = 1'b0;
      AluOverflow = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
`ifdef ALU_MUL_SIGNED_EN
    p = longint'($signed(a)) * longint'($signed(b));
`else
    p = longint'(a) * longint'(b);
`endif
    return p[31:0];
  endfunction

  function automatic logic ref_inv_expected(input logic [W-1:0] b);
`ifdef ALU_MUL_SIGNED_EN
    return b[W-1];
`else
    return 1'b0;
`endif
  endfunction

  // Called at the negedge of ITER cycle 1 with Start already low. Optionally
  // pokes Start with other operands at cycle poke_at. Returns at the Done cycle.
  task automatic finish_mul(input string tag, input logic [W-1:0] b, input logic [31:0] exp,
                            input int poke_at, input logic [W-1:0] pa, input logic [W-1:0] pb);
    int cyc = 1;
    int busy_n = 0;
    int inv_n = 0;
    int inv_cyc = 0;
    int bad_op = 0;
    while (!Done && cyc < 40) begin
      if (Busy) busy_n++;
      if (Busy && AluOp !== 3'b100) bad_op++;
      if (AluBInvert) begin inv_n++; inv_cyc = cyc; end
      if (cyc == poke_at) begin Start = 1'b1; MulA = pa; MulB = pb; end
      else Start = 1'b0;
      @(negedge Clock);
      cyc++;
    end
    Start = 1'b0;
    check({tag, " done_cycle"}, 64'(cyc), 64'(W + 1));
    check({tag, " busy_cycles"}, 64'(busy_n), 64'(W));
    check({tag, " product"}, 64'(Product), 64'(exp));
    check({tag, " aluop"}, 64'(bad_op), 64'd0);
    check({tag, " invert_count"}, 64'(inv_n), 64'(ref_inv_expected(b)));
    if (ref_inv_expected(b)) check({tag, " invert_cycle"}, 64'(inv_cyc), 64'(W));
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge Clock);
    Start = 1'b1; MulA = a; MulB = b;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic do_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    launch(a, b);
    finish_mul(tag, b, ref_mul(a, b), 0, '0, '0);
    @(negedge Clock);
    check({tag, " done_pulse"}, 64'(Done), 64'd0);
  endtask

  initial begin
    logic [W-1:0] a, b, a2, b2;
    int done_seen;
    Reset = 1'b1; Start = 1'b0; MulA = '0; MulB = '0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    check("rst busy", 64'(Busy), 64'd0);
    check("rst done", 64'(Done), 64'd0);
    check("rst product", 64'(Product), 64'd0);
    check("rst aluop", 64'(AluOp), 64'd0);
    check("rst alua", 64'(AluA), 64'd0);
    check("rst alub", 64'(AluB), 64'd0);
    check("rst inv_cin", 64'({AluBInvert, AluCin}), 64'd0);
    Reset = 1'b0;

    do_mul("3x5", 16'd3, 16'd5);
    do_mul("ffff_sq", 16'hFFFF, 16'hFFFF);
    do_mul("1234x0", 16'h1234, 16'h0000);
    do_mul("0x1234", 16'h0000, 16'h1234);
    do_mul("m3x7", 16'hFFFD, 16'd7);
    do_mul("7xm3", 16'd7, 16'hFFFD);
    do_mul("8000_sq", 16'h8000, 16'h8000);
`ifdef ALU_MUL_SIGNED_EN
    check("const m3x7", 64'(ref_mul(16'hFFFD, 16'd7)), 64'hFFFFFFEB);
`else
    check("const ffff_sq", 64'(ref_mul(16'hFFFF, 16'hFFFF)), 64'hFFFE0001);
`endif

    for (int i = 0; i < 20; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      do_mul($sformatf("rnd%0d", i), a, b);
    end

    // Start while busy is ignored; Start held through DONE is taken the cycle after.
    a = W'($urandom); b = W'($urandom); a2 = W'($urandom); b2 = W'($urandom);
    launch(a, b);
    finish_mul("busy_poke", b, ref_mul(a, b), 5, a2, b2);
    Start = 1'b1; MulA = a2; MulB = b2;
    @(negedge Clock);
    check("poke idle_after_done", 64'(Busy), 64'd0);
    check("poke product_held", 64'(Product), 64'(ref_mul(a, b)));
    @(negedge Clock);
    Start = 1'b0;
    check("poke accepted", 64'(Busy), 64'd1);
    finish_mul("second", b2, ref_mul(a2, b2), 0, '0, '0);
    @(negedge Clock);

    // Reset in ITER cycle 8 aborts and clears Product.
    launch(16'd9, 16'd11);
    repeat (7) @(negedge Clock);
    check("pre_rst busy", 64'(Busy), 64'd1);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check("abort busy", 64'(Busy), 64'd0);
    check("abort product", 64'(Product), 64'd0);
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (Done || Busy) done_seen++;
      @(negedge Clock);
    end
    check("abort no_done", 64'(done_seen), 64'd0);
    do_mul("2x2", 16'd2, 16'd2);
    check("2x2 value", 64'(Product), 64'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle shift-add multiply sequencer that drives the shared 16-bit ALU. It holds the accumulator and multiplier registers and issues one ADD, or SUB for the signed final step, to the ALU per cycle. It delivers a 32-bit product after 16 iterations. It sits beside the single-cycle datapath, and the control unit stalls on `Busy` while a multiply instruction executes.

## Interface
- `WIDTH`, default 16: operand width; the ALU width and iteration count are both equal to it.
- `Clock`  in  1  rising-edge clock.
- `Reset`  in  1  synchronous, active-high reset.
- `Start`  in  1  request; sampled only in IDLE.
- `MulA`  in  WIDTH  multiplicand; captured on an accepted Start.
- `MulB`  in  WIDTH  multiplier; captured on an accepted Start.
- `Busy`  out  1  high during ITER.
- `Done`  out  1  one-cycle pulse in DONE.
- `Product`  out  2*WIDTH  result; valid from Done until the next accepted Start.
- `AluA`  out  WIDTH  to ALU A; carries the accumulator high half.
- `AluB`  out  WIDTH  to ALU B; carries the multiplicand or zero.
- `AluOp`  out  3  to ALU Op; the sequencer only drives 3'b100 (adder path).
- `AluBInvert`  out  1  to ALU BInvert.
- `AluCin`  out  1  to ALU bit-0 carry-in.
- `AluResult`  in  WIDTH  from ALU.
- `AluCarryOut`  in  1  carry out of ALU MSB.
- `AluOverflow`  in  1  signed overflow of the ALU MSB (carry-in XOR carry-out of bit WIDTH-1).

## Operation
- States: IDLE, ITER, DONE. Transitions:
  - IDLE to ITER on Start.
  - ITER to DONE when the iteration counter reaches WIDTH-1.
  - DONE to IDLE unconditionally.
- On Start accept:
  - Mcand <= MulA.
  - Hi <= 0.
  - Lo <= MulB.
  - Cnt <= 0.
- In ITER, every cycle:
  - AluA = Hi.
  - AluB = Lo[0] ? Mcand : 0.
  - AluOp = 3'b100.
  - AluBInvert = AluCin = 0, except for the signed last step (see Configuration).
- Per-cycle update: {Hi, Lo} <= {Ext, AluResult, Lo[WIDTH-1:1]}, then Cnt++.
  - Unsigned: Ext = AluCarryOut.
  - Signed: Ext = AluResult[WIDTH-1] ^ AluOverflow, which is the true sign of the WIDTH+1-bit sum.
- Product = {Hi, Lo}. It is a registered copy updated only on entry to DONE.
- Outside ITER, the sequencer drives all ALU-side outputs to 0, which selects AND with zero operands.
- Start in ITER or DONE is ignored and not queued.
- MulB = 0 or MulA = 0 still takes the full WIDTH iterations. There is no early exit.

## Timing
- Reset values:
  - State = IDLE.
  - Busy = 0, Done = 0.
  - Product = 0.
  - All ALU outputs = 0.
  - Internal Hi, Lo, Mcand and Cnt = 0.
- Reset dominates Start in the same cycle. Reset during ITER aborts the multiply, returns to IDLE and clears Product.
- Latency: Start high at edge 0 gives Busy high for cycles 1..WIDTH and Done high in cycle WIDTH+1. This is 17 cycles for WIDTH=16.
- A new Start is accepted in the cycle after Done, so the back-to-back throughput is one product per WIDTH+2 cycles.
- The ALU path is combinational within the cycle. The ALU result is registered at the end of each ITER cycle.
- Cnt is $clog2(WIDTH) bits wide and wraps to 0 on entering DONE.

## Configuration
- `ALU_MUL_SIGNED_EN` defined: operands are two's complement.
  - Ext uses the sign-correct formula above.
  - On the final iteration (Cnt = WIDTH-1) with Lo[0] = 1, the sequencer drives AluBInvert = 1 and AluCin = 1, so the ALU computes Hi - Mcand.
  - Product is the signed 2*WIDTH-bit result.
- Undefined: operands are unsigned.
  - Ext = AluCarryOut.
  - AluBInvert and AluCin are tied 0.
  - `AluOverflow` is unused.

## Test plan
- Reset check: assert Reset for 2 cycles. Require Busy = Done = 0, Product = 0 and AluOp = 0.
- Unsigned 3 x 5: pulse Start. Require Busy for exactly 16 cycles, Done in cycle 17 and Product = 32'd15.
- Unsigned max: 0xFFFF x 0xFFFF gives Product = 0xFFFE0001. 0x1234 x 0 gives Product = 0 after the full 17 cycles.
- Signed build: -3 x 7 gives 32'hFFFFFFEB. 7 x -3 gives 32'hFFFFFFEB, with AluBInvert = 1 seen only in the last ITER cycle. 0x8000 x 0x8000 gives 32'h40000000.
- Start while busy: pulse Start again at cycle 5 with new operands. Require it to be ignored, the first product returned unchanged, and the new Start accepted the cycle after Done.
- Reset mid-op: assert Reset at cycle 8 of ITER. Require IDLE next cycle, Product = 0 and no Done. A following 2 x 2 returns 4.
